mcp3008_responder: RTL and testbench

Synthesizable emulator of an MCP3008-class 10-bit, 8-channel SPI ADC: the responder end of the ADC link whose initiator drives AD_CLK/CS/DIN and captures DOUT. It oversamples the SPI pins on the system clock, decodes the start/SGL/D2..D0 command, latches the selected channel code from a parallel input bus, and shifts the result out on DOUT with datasheet framing. It sits in place of the physical ADC for closed-loop bring-up and regression of the initiator, the FFT input path and the display chain.

---
 rtl/mcp3008_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3008_responder.sv
// mcp3008_responder: emulates the responder side of an MCP3008-class
// 10-bit, 8-channel SPI ADC. The SPI pins are oversampled on clk. A
// start/SGL/D2..D0 command is decoded, the selected code is latched from
// ch_data, and the result is shifted out on dout with datasheet framing:
// null bit, B9..B0, B1..B9, then zeros until cs is released.
`timescale 1ns/1ps

module mcp3008_responder #(
    parameter int CH_BITS = 10,
    parameter int NUM_CH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ad_clk,
    input  logic                      cs,
    input  logic                      din,
    input  logic [NUM_CH*CH_BITS-1:0] ch_data,
    output logic                      dout,
    output logic                      dout_oe,
    output logic                      conv_done,
    output logic                      conv_single,
    output logic [2:0]                conv_channel,
    output logic [CH_BITS-1:0]        conv_code
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CMD,
        ST_SAMPLE,
        ST_NULL,
        ST_MSB,
        ST_LSB,
        ST_ZERO
    } state_t;

    localparam logic [3:0] LAST_MSB = 4'(CH_BITS - 1);
    localparam logic [3:0] LAST_LSB = 4'(CH_BITS - 2);
    localparam logic [3:0] LAST_CMD = 4'd3;

    // Synchronizers and edge detection
    logic       ad_clk_s1_q, ad_clk_s2_q, ad_clk_s3_q;
    logic       cs_s1_q, cs_s2_q;
    logic       din_s1_q, din_s2_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       ad_rise, ad_fall;

    // FSM and output registers
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           cmd_q, cmd_d;
    logic                 dout_q, dout_d;
    logic                 dout_oe_q, dout_oe_d;
    logic                 conv_done_q, conv_done_d;
    logic                 conv_single_q, conv_single_d;
    logic [2:0]           conv_channel_q, conv_channel_d;
    logic [CH_BITS-1:0]   conv_code_q, conv_code_d;

    // Channel view; channels beyond NUM_CH read as zero
    logic [CH_BITS-1:0]   ch_arr [8];
    logic [CH_BITS-1:0]   ch_pos, ch_neg, code_sel;

    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NUM_CH) begin : g_used
            assign ch_arr[g] = ch_data[g*CH_BITS +: CH_BITS];
        end else begin : g_empty
            assign ch_arr[g] = '0;
        end
    end

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_clk_s1_q <= 1'b0;
            ad_clk_s2_q <= 1'b0;
            ad_clk_s3_q <= 1'b0;
            // NOTE: cs is active-low, so its synchronizer resets to the
            // inactive level; resetting to 0 would fake a selected frame.
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            din_s1_q    <= 1'b0;
            din_s2_q    <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what forms a real shift chain.
            ad_clk_s1_q <= ad_clk;
            ad_clk_s2_q <= ad_clk_s1_q;
            ad_clk_s3_q <= ad_clk_s2_q;
            cs_s1_q     <= cs;
            cs_s2_q     <= cs_s1_q;
            din_s1_q    <= din;
            din_s2_q    <= din_s1_q;
            fill_q      <= {fill_q[0], 1'b1};
            // Arm only once a genuine high cs has passed the synchronizer,
            // so a frame cut by reset is never resumed.
            armed_q     <= armed_q | (cs_s2_q & fill_q[1]);
        end
    end

    assign ad_rise = ad_clk_s2_q & ~ad_clk_s3_q;
    assign ad_fall = ~ad_clk_s2_q & ad_clk_s3_q;

    // Conversion result: single-ended pick or clamped differential
    always_comb begin
        ch_pos   = ch_arr[cmd_q[2:0]];
        ch_neg   = ch_arr[cmd_q[2:0] ^ 3'd1];
        code_sel = '0;
        if (cmd_q[3]) begin
            code_sel = ch_pos;
        end else if (ch_pos > ch_neg) begin
            code_sel = ch_pos - ch_neg;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            cmd_q          <= '0;
            dout_q         <= 1'b0;
            dout_oe_q      <= 1'b0;
            conv_done_q    <= 1'b0;
            conv_single_q  <= 1'b0;
            conv_channel_q <= '0;
            conv_code_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            dout_q         <= dout_d;
            dout_oe_q      <= dout_oe_d;
            conv_done_q    <= conv_done_d;
            conv_single_q  <= conv_single_d;
            conv_channel_q <= conv_channel_d;
            conv_code_q    <= conv_code_d;
        end
    end

    // Frame sequencing; a deasserted cs overrides any pending edge
    always_comb begin
        // NOTE: every target gets a default first so no path can leave a
        // variable unassigned and infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        dout_d         = dout_q;
        dout_oe_d      = dout_oe_q;
        conv_done_d    = 1'b0;
        conv_single_d  = conv_single_q;
        conv_channel_d = conv_channel_q;
        conv_code_d    = conv_code_q;

        if (cs_s2_q) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            cmd_d     = '0;
            dout_d    = 1'b0;
            dout_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    dout_d    = 1'b0;
                    dout_oe_d = 1'b0;
                    cnt_d     = '0;
                    if (armed_q) state_d = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (ad_rise && din_s2_q) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    if (ad_rise) begin
                        cmd_d = {cmd_q[2:0], din_s2_q};
                        if (cnt_q == LAST_CMD) begin
                            state_d = ST_SAMPLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (ad_rise) begin
                        conv_done_d    = 1'b1;
                        conv_single_d  = cmd_q[3];
                        conv_channel_d = cmd_q[2:0];
                        conv_code_d    = code_sel;
                        state_d        = ST_NULL;
                    end
                end
                ST_NULL: begin
                    if (ad_fall) begin
                        dout_oe_d = 1'b1;
                        dout_d    = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_MSB;
                    end
                end
                ST_MSB: begin
                    if (ad_fall) begin
                        dout_d = conv_code_q[LAST_MSB - cnt_q];
                        if (cnt_q == LAST_MSB) begin
                            state_d = ST_LSB;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_LSB: begin
                    if (ad_fall) begin
                        dout_d = conv_code_q[cnt_q + 4'd1];
                        if (cnt_q == LAST_LSB) begin
                            state_d = ST_ZERO;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_ZERO: begin
                    if (ad_fall) dout_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dout         = dout_q;
    assign dout_oe      = dout_oe_q;
    assign conv_done    = conv_done_q;
    assign conv_single  = conv_single_q;
    assign conv_channel = conv_channel_q;
    assign conv_code    = conv_code_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Testbench for mcp3008_responder: acts as the SPI initiator at 8x
// oversampling and compares every captured frame with a reference model
// derived from the ADC's framing rules.
`timescale 1ns/1ps

module tb_mcp3008_responder;

    localparam int CH_BITS = 10;
    localparam int NUM_CH  = 8;
    localparam int TAIL    = 3;
    localparam int FBITS   = 1 + CH_BITS + (CH_BITS - 1) + TAIL;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ad_clk = 1'b0;
    logic                      cs = 1'b1;
    logic                      din = 1'b0;
    logic [NUM_CH*CH_BITS-1:0] ch_data = '0;
    logic                      dout, dout_oe, conv_done, conv_single;
    logic [2:0]                conv_channel;
    logic [CH_BITS-1:0]        conv_code;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int off_viol     = 0;
    int chv [NUM_CH];

    always #5 clk = ~clk;

    mcp3008_responder #(.CH_BITS(CH_BITS), .NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ad_clk       (ad_clk),
        .cs           (cs),
        .din          (din),
        .ch_data      (ch_data),
        .dout         (dout),
        .dout_oe      (dout_oe),
        .conv_done    (conv_done),
        .conv_single  (conv_single),
        .conv_channel (conv_channel),
        .conv_code    (conv_code)
    );

    // Count conv_done cycles and watch that dout is quiet while undriven
    always @(negedge clk) begin
        if (conv_done) done_cnt++;
        if (!dout_oe && dout) off_viol++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ch();
        for (int i = 0; i < NUM_CH; i++) ch_data[i*CH_BITS +: CH_BITS] = chv[i][CH_BITS-1:0];
    endtask

    // One ad_clk period: din set while low, dout captured at the rise
    task automatic spi_bit(input logic d, output logic cap, output logic oe_cap);
        din = d;
        repeat (4) @(negedge clk);
        ad_clk = 1'b1;
        cap    = dout;
        oe_cap = dout_oe;
        repeat (4) @(negedge clk);
        ad_clk = 1'b0;
    endtask

    // Reference: what an ideal ADC converts for this command
    function automatic int model_code(input logic sgl, input logic [2:0] ch);
        int p, n;
        p = (int'(ch) < NUM_CH) ? chv[ch] : 0;
        n = (int'(ch ^ 3'd1) < NUM_CH) ? chv[ch ^ 3'd1] : 0;
        if (sgl) return p;
        return (p > n) ? p - n : 0;
    endfunction

    // Reference: bits the initiator sees from the null bit onwards
    function automatic logic [FBITS-1:0] model_frame(input int code);
        bit               q[$];
        logic [FBITS-1:0] r;
        q.push_back(1'b0);
        for (int b = CH_BITS - 1; b >= 0; b--) q.push_back(((code >> b) & 1) != 0);
        for (int b = 1; b < CH_BITS; b++) q.push_back(((code >> b) & 1) != 0);
        for (int b = 0; b < TAIL; b++) q.push_back(1'b0);
        r = '0;
        foreach (q[i]) r = {r[FBITS-2:0], q[i]};
        return r;
    endfunction

    task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch, input bit scramble);
        logic             c, o;
        logic [FBITS-1:0] got;
        int               code, d0;
        bit               oe_ok;
        cs = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        repeat (lead) spi_bit(1'b0, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(sgl, c, o);
        for (int k = 2; k >= 0; k--) spi_bit(ch[k], c, o);
        code = model_code(sgl, ch);
        spi_bit(1'b0, c, o);
        check("pre_null_oe", 32'(o), 0);
        if (scramble) begin
            for (int i = 0; i < NUM_CH; i++) chv[i] = int'($urandom_range(0, 1023));
            set_ch();
        end
        oe_ok = 1'b1;
        got   = '0;
        for (int i = 0; i < FBITS; i++) begin
            spi_bit(1'($urandom_range(0, 1)), c, o);
            got = {got[FBITS-2:0], c};
            if (!o) oe_ok = 1'b0;
        end
        check("frame_bits", 32'(got), 32'(model_frame(code)));
        check("frame_oe", 32'(oe_ok), 1);
        check("done_pulses", done_cnt - d0, 1);
        check("conv_code", 32'(conv_code), code);
        check("conv_channel", 32'(conv_channel), 32'(ch));
        check("conv_single", 32'(conv_single), 32'(sgl));
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_oe", 32'(dout_oe), 0);
    endtask

    initial begin
        logic c, o;
        int   d0, saved;
        bit   oe_seen;
        logic sgl;
        logic [2:0] ch;

        for (int i = 0; i < NUM_CH; i++) chv[i] = 0;
        set_ch();
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_dout_oe", 32'(dout_oe), 0);
        check("rst_conv_done", 32'(conv_done), 0);
        check("rst_conv_single", 32'(conv_single), 0);
        check("rst_conv_channel", 32'(conv_channel), 0);
        check("rst_conv_code", 32'(conv_code), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single-ended channel 3
        for (int i = 0; i < NUM_CH; i++) chv[i] = int'($urandom_range(0, 1023));
        chv[3] = 'h2A5;
        set_ch();
        run_frame(0, 1'b1, 3'd3, 1'b0);

        // Differential pairs in both directions
        chv[0] = 'h300;
        chv[1] = 'h100;
        set_ch();
        run_frame(0, 1'b0, 3'd0, 1'b0);
        run_frame(0, 1'b0, 3'd1, 1'b0);

        // Leading zeros before the start bit
        run_frame(7, 1'b1, 3'd3, 1'b0);

        // Abort after the D1 rise: nothing latched
        cs = 1'b0;
        repeat (4) @(negedge clk);
        d0    = done_cnt;
        saved = int'(conv_code);
        spi_bit(1'b1, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b0, c, o);
        spi_bit(1'b1, c, o);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_oe", 32'(dout_oe), 0);
        repeat (9) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_code_kept", 32'(conv_code), saved);
        run_frame(0, 1'b1, 3'd3, 1'b0);

        // Abort mid-data: dout_oe drops exactly three clk after cs rises
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_bit(1'b1, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b0, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b0, c, o);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, c, o);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_oe_hold", 32'(dout_oe), 1);
        @(negedge clk);
        check("abort_oe_drop", 32'(dout_oe), 0);
        check("abort_dout_drop", 32'(dout), 0);
        repeat (4) @(negedge clk);
        run_frame(1, 1'b1, 3'd5, 1'b0);

        // Reset in the middle of B5, cs kept low
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_bit(1'b1, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b0, c, o);
        spi_bit(1'b1, c, o);
        spi_bit(1'b0, c, o);
        spi_bit(1'b0, c, o);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, c, o);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_dout_oe", 32'(dout_oe), 0);
        check("midrst_dout", 32'(dout), 0);
        check("midrst_conv_code", 32'(conv_code), 0);
        check("midrst_conv_channel", 32'(conv_channel), 0);
        check("midrst_conv_single", 32'(conv_single), 0);
        check("midrst_conv_done", 32'(conv_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0      = done_cnt;
        oe_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            spi_bit(1'($urandom_range(0, 1)), c, o);
            if (o) oe_seen = 1'b1;
        end
        check("postrst_silent", 32'(oe_seen), 0);
        check("postrst_no_done", done_cnt - d0, 0);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        run_frame(0, 1'b1, 3'd2, 1'b0);

        // Back-to-back frames over every channel with distinct codes
        for (int i = 0; i < NUM_CH; i++) chv[i] = i * 128 + int'($urandom_range(0, 127));
        set_ch();
        for (int i = 0; i < NUM_CH; i++) run_frame(0, 1'b1, 3'(i), 1'b0);

        // Randomized frames, including equal and extreme codes; channel
        // data is rescrambled after each latch
        for (int n = 0; n < 24; n++) begin
            sgl = 1'($urandom_range(0, 1));
            ch  = 3'($urandom_range(0, 7));
            for (int i = 0; i < NUM_CH; i++) chv[i] = int'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0: chv[ch ^ 3'd1] = chv[ch];
                1: begin chv[ch] = 1023; chv[ch ^ 3'd1] = 0; end
                2: begin chv[ch] = 0; chv[ch ^ 3'd1] = 1023; end
                default: ;
            endcase
            set_ch();
            run_frame(int'($urandom_range(0, 3)), sgl, ch, 1'b1);
        end

        check("dout_zero_when_off", off_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
